// File: rtl/ascon_csr_ctl_if.sv
// Avalon-MM slave bus bundle for the ASCON CSR front-end.
// The host side drives the request fields; the register block returns
// registered read data with a one-cycle readdatavalid strobe.
interface ascon_csr_ctl_if #(
   parameter int ADDR_W = 6
);
   logic              chipselect;
   logic              write;
   logic              read;
   logic [ADDR_W-1:0] address;
   logic [31:0]       writedata;
   logic [31:0]       readdata;
   logic              readdatavalid;

   modport master (
      output chipselect, write, read, address, writedata,
      input  readdata, readdatavalid
   );

   modport slave (
      input  chipselect, write, read, address, writedata,
      output readdata, readdatavalid
   );
endinterface

// File: rtl/ascon_csr_ctl.sv
// Avalon-MM register front-end for the ASCON core.
// Holds key/nonce/AD/PT/expected-tag registers, sequences one core run per
// start request (IDLE -> START -> BUSY -> CAPTURE), snapshots the core result
// and tag on completion, and reports sticky W1C status plus a level interrupt.
// Configuration writes are locked out while a run is in flight, and a
// watchdog aborts a run whose done never arrives.
module ascon_csr_ctl #(
   parameter int N_BLK       = 2,
   parameter int ADDR_W      = 6,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   ascon_csr_ctl_if.slave       bus,
   output logic                 irq,
   output logic                 start,
   output logic [1:0]           encrypt_decrypt,
   output logic [127:0]         key,
   output logic [127:0]         nonce,
   output logic [64*N_BLK-1:0]  associated_data,
   output logic [64*N_BLK-1:0]  plaintext_in,
   output logic [127:0]         tag_in,
   input  logic [64*N_BLK-1:0]  ciphertext_out,
   input  logic [64*N_BLK-1:0]  plaintext_out,
   input  logic [127:0]         tag,
   input  logic                 done,
   input  logic                 error
);

   // Word counts and address map (word addresses).
   localparam int NW      = 2 * N_BLK;
   localparam int BW      = (NW > 1) ? $clog2(NW) : 1;
   localparam int A_CTRL  = 0;
   localparam int A_STAT  = 1;
   localparam int A_KEY   = 2;
   localparam int A_NONCE = 6;
   localparam int A_AD    = 10;
   localparam int A_PT    = 10 + NW;
   localparam int A_RES   = 10 + 2 * NW;
   localparam int A_TAG   = 10 + 3 * NW;
   localparam int A_END   = 14 + 3 * NW;

   // Watchdog counter sizing; the counter only needs to reach TIMEOUT_CYC-1.
   localparam int               CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_START   = 2'd1,
      ST_BUSY    = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   state_t           state_r, state_nx;
   logic [CNT_W-1:0] cnt_r;

   // Word-wide register storage; even word of a block is its upper half.
   logic [31:0] key_w_r   [4];
   logic [31:0] nonce_w_r [4];
   logic [31:0] tagin_w_r [4];
   logic [31:0] tagcap_w_r[4];
   logic [31:0] ad_w_r    [NW];
   logic [31:0] pt_w_r    [NW];
   logic [31:0] res_w_r   [NW];

   logic [1:0]  mode_r;
   logic        irq_en_r, irq_r, start_r, err_smp_r;
   logic        done_st_r, err_st_r, to_st_r, wrlock_st_r;
   logic [31:0] readdata_r;
   logic        readdatavalid_r;

   logic [ADDR_W-1:0] addr_s;
   logic [31:0]       addr_w_s;
   logic              wr_s, rd_s, busy_s, wr_ok_s, start_req_s;
   logic              hit_ctrl_s, hit_stat_s, hit_key_s, hit_nonce_s;
   logic              hit_ad_s, hit_pt_s, hit_res_s, hit_tag_s, lock_hit_s;
   logic [1:0]        key_idx_s, nonce_idx_s, tag_idx_s;
   logic [BW-1:0]     ad_idx_s, pt_idx_s, res_idx_s;
   logic              to_hit_s, to_fire_s, cap_s;
   logic [3:0]        clr_s;
   logic              done_nx_s, err_nx_s, to_nx_s, wrlock_nx_s, irq_en_nx_s, irq_nx_s;
   logic [31:0]       rd_data_s;
   logic [64*N_BLK-1:0] res_src_s;

   assign addr_s   = bus.address;
   assign addr_w_s = 32'(addr_s);
   assign wr_s     = bus.chipselect & bus.write;
   assign rd_s     = bus.chipselect & bus.read;
   assign busy_s   = (state_r != ST_IDLE);
   assign wr_ok_s  = wr_s & ~busy_s;

   // Region decode; low address bits minus the region base give the word index.
   assign hit_ctrl_s  = (addr_w_s == 32'(A_CTRL));
   assign hit_stat_s  = (addr_w_s == 32'(A_STAT));
   assign hit_key_s   = (addr_w_s >= 32'(A_KEY))   && (addr_w_s < 32'(A_NONCE));
   assign hit_nonce_s = (addr_w_s >= 32'(A_NONCE)) && (addr_w_s < 32'(A_AD));
   assign hit_ad_s    = (addr_w_s >= 32'(A_AD))    && (addr_w_s < 32'(A_PT));
   assign hit_pt_s    = (addr_w_s >= 32'(A_PT))    && (addr_w_s < 32'(A_RES));
   assign hit_res_s   = (addr_w_s >= 32'(A_RES))   && (addr_w_s < 32'(A_TAG));
   assign hit_tag_s   = (addr_w_s >= 32'(A_TAG))   && (addr_w_s < 32'(A_END));
   assign lock_hit_s  = hit_ctrl_s | hit_key_s | hit_nonce_s | hit_ad_s | hit_pt_s | hit_tag_s;

   assign key_idx_s   = addr_s[1:0] - 2'(A_KEY);
   assign nonce_idx_s = addr_s[1:0] - 2'(A_NONCE);
   assign tag_idx_s   = addr_s[1:0] - 2'(A_TAG);
   assign ad_idx_s    = addr_s[BW-1:0] - BW'(A_AD);
   assign pt_idx_s    = addr_s[BW-1:0] - BW'(A_PT);
   assign res_idx_s   = addr_s[BW-1:0] - BW'(A_RES);

   assign start_req_s = wr_ok_s & hit_ctrl_s & bus.writedata[0];
   assign to_hit_s    = (TIMEOUT_CYC != 0) && (cnt_r == TO_LAST);
   assign to_fire_s   = (state_r == ST_BUSY) && !done && to_hit_s;
   assign cap_s       = (state_r == ST_CAPTURE);
   assign res_src_s   = (mode_r == 2'd0) ? ciphertext_out : plaintext_out;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nx;
   end

   // FSM next-state; done takes priority over the watchdog in the same cycle.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_req_s) state_nx = ST_START;
            else             state_nx = ST_IDLE;
         end
         ST_START:   state_nx = ST_BUSY;
         ST_BUSY: begin
            if (done)          state_nx = ST_CAPTURE;
            else if (to_hit_s) state_nx = ST_IDLE;
            else               state_nx = ST_BUSY;
         end
         ST_CAPTURE: state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // Watchdog counter: cleared in START, counts each BUSY cycle.
   always_ff @(posedge clk) begin
      if (rst)                       cnt_r <= '0;
      else if (state_r == ST_START)  cnt_r <= '0;
      else if (state_r == ST_BUSY)   cnt_r <= cnt_r + CNT_ONE;
      else                           cnt_r <= cnt_r;
   end

   // Host-writable configuration; dropped entirely while a run is in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_w_r   <= '{default: 32'h0};
         nonce_w_r <= '{default: 32'h0};
         tagin_w_r <= '{default: 32'h0};
         ad_w_r    <= '{default: 32'h0};
         pt_w_r    <= '{default: 32'h0};
         mode_r    <= 2'd0;
      end else if (wr_ok_s) begin
         if (hit_ctrl_s)  mode_r                 <= bus.writedata[2:1];
         if (hit_key_s)   key_w_r[key_idx_s]     <= bus.writedata;
         if (hit_nonce_s) nonce_w_r[nonce_idx_s] <= bus.writedata;
         if (hit_ad_s)    ad_w_r[ad_idx_s]       <= bus.writedata;
         if (hit_pt_s)    pt_w_r[pt_idx_s]       <= bus.writedata;
         if (hit_tag_s)   tagin_w_r[tag_idx_s]   <= bus.writedata;
      end
   end

   // Core error is only meaningful alongside done, so sample it there.
   always_ff @(posedge clk) begin
      if (rst)                               err_smp_r <= 1'b0;
      else if ((state_r == ST_BUSY) && done) err_smp_r <= error;
      else                                   err_smp_r <= err_smp_r;
   end

   // Result/tag snapshot taken once per run so reads never see live core outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_w_r    <= '{default: 32'h0};
         tagcap_w_r <= '{default: 32'h0};
      end else if (cap_s) begin
         for (int b = 0; b < N_BLK; b++) begin
            res_w_r[2*b]   <= res_src_s[64*b+32 +: 32];
            res_w_r[2*b+1] <= res_src_s[64*b +: 32];
         end
         for (int i = 0; i < 4; i++) begin
            tagcap_w_r[i] <= tag[32*(3-i) +: 32];
         end
      end
   end

   // Sticky status next values: W1C clear first, hardware set wins.
   always_comb begin
      if (wr_s && hit_stat_s) clr_s = bus.writedata[4:1];
      else                    clr_s = 4'h0;
      done_nx_s   = (done_st_r   & ~clr_s[0]) | cap_s;
      err_nx_s    = (err_st_r    & ~clr_s[1]) | (cap_s & err_smp_r);
      to_nx_s     = (to_st_r     & ~clr_s[2]) | to_fire_s;
      wrlock_nx_s = (wrlock_st_r & ~clr_s[3]) | (wr_s & busy_s & lock_hit_s);
      if (wr_ok_s && hit_ctrl_s) irq_en_nx_s = bus.writedata[3];
      else                       irq_en_nx_s = irq_en_r;
      irq_nx_s = irq_en_nx_s & (done_nx_s | err_nx_s | to_nx_s);
   end

   // Status, interrupt enable, interrupt and start pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_st_r   <= 1'b0;
         err_st_r    <= 1'b0;
         to_st_r     <= 1'b0;
         wrlock_st_r <= 1'b0;
         irq_en_r    <= 1'b0;
         irq_r       <= 1'b0;
         start_r     <= 1'b0;
      end else begin
         done_st_r   <= done_nx_s;
         err_st_r    <= err_nx_s;
         to_st_r     <= to_nx_s;
         wrlock_st_r <= wrlock_nx_s;
         irq_en_r    <= irq_en_nx_s;
         irq_r       <= irq_nx_s;
         start_r     <= (state_nx == ST_START);
      end
   end

   // Read mux over the current register contents.
   always_comb begin
      rd_data_s = 32'h0;
      if (hit_ctrl_s)       rd_data_s = {28'h0, irq_en_r, mode_r, 1'b0};
      else if (hit_stat_s)  rd_data_s = {27'h0, wrlock_st_r, to_st_r, err_st_r, done_st_r, busy_s};
      else if (hit_key_s)   rd_data_s = key_w_r[key_idx_s];
      else if (hit_nonce_s) rd_data_s = nonce_w_r[nonce_idx_s];
      else if (hit_ad_s)    rd_data_s = ad_w_r[ad_idx_s];
      else if (hit_pt_s)    rd_data_s = pt_w_r[pt_idx_s];
      else if (hit_res_s)   rd_data_s = res_w_r[res_idx_s];
      else if (hit_tag_s)   rd_data_s = tagcap_w_r[tag_idx_s];
      else                  rd_data_s = 32'h0;
   end

   // Registered read response, one cycle after the accepted read.
   always_ff @(posedge clk) begin
      if (rst) begin
         readdata_r      <= 32'h0;
         readdatavalid_r <= 1'b0;
      end else begin
         readdata_r      <= rd_s ? rd_data_s : readdata_r;
         readdatavalid_r <= rd_s;
      end
   end

   assign bus.readdata      = readdata_r;
   assign bus.readdatavalid = readdatavalid_r;
   assign irq               = irq_r;
   assign start             = start_r;
   assign encrypt_decrypt   = mode_r;
   assign key               = {key_w_r[0], key_w_r[1], key_w_r[2], key_w_r[3]};
   assign nonce             = {nonce_w_r[0], nonce_w_r[1], nonce_w_r[2], nonce_w_r[3]};
   assign tag_in            = {tagin_w_r[0], tagin_w_r[1], tagin_w_r[2], tagin_w_r[3]};

   for (genvar b = 0; b < N_BLK; b++) begin : g_pack
      assign associated_data[64*b +: 64] = {ad_w_r[2*b], ad_w_r[2*b+1]};
      assign plaintext_in[64*b +: 64]    = {pt_w_r[2*b], pt_w_r[2*b+1]};
   end

endmodule

// File: tb/tb_ascon_csr_ctl.sv
// Bench for ascon_csr_ctl: a default-timeout instance exercises the main
// flows, a TIMEOUT_CYC=16 instance exercises the watchdog. Read responses are
// checked by scoreboards fed when each read is issued.
module tb_ascon_csr_ctl;
   localparam int NB = 2;
   localparam int AW = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, rst_to;
   ascon_csr_ctl_if #(.ADDR_W(AW)) bus ();
   ascon_csr_ctl_if #(.ADDR_W(AW)) bus_to ();

   logic [64*NB-1:0] ct_out, pt_out;
   logic [127:0]     tag_v;
   logic             done, error, done_to;

   logic             irq, start, irq_to, start_to;
   logic [1:0]       mode, mode_to;
   logic [127:0]     key, nonce, tag_in, key_to, nonce_to, tag_in_to;
   logic [64*NB-1:0] ad, pt_in, ad_to, pt_in_to;

   ascon_csr_ctl #(.N_BLK(NB), .ADDR_W(AW), .TIMEOUT_CYC(4096)) u_dut (
      .clk(clk), .rst(rst), .bus(bus), .irq(irq), .start(start),
      .encrypt_decrypt(mode), .key(key), .nonce(nonce),
      .associated_data(ad), .plaintext_in(pt_in), .tag_in(tag_in),
      .ciphertext_out(ct_out), .plaintext_out(pt_out), .tag(tag_v),
      .done(done), .error(error)
   );

   ascon_csr_ctl #(.N_BLK(NB), .ADDR_W(AW), .TIMEOUT_CYC(16)) u_dut_to (
      .clk(clk), .rst(rst_to), .bus(bus_to), .irq(irq_to), .start(start_to),
      .encrypt_decrypt(mode_to), .key(key_to), .nonce(nonce_to),
      .associated_data(ad_to), .plaintext_in(pt_in_to), .tag_in(tag_in_to),
      .ciphertext_out(ct_out), .plaintext_out(pt_out), .tag(tag_v),
      .done(done_to), .error(error)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int n_start = 0;
   int t0;

   typedef struct {
      logic [31:0] d;
      int          c;
   } rd_t;
   rd_t rdq[$];
   rd_t rdq_to[$];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (start) n_start <= n_start + 1;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard pop for the main instance.
   always @(negedge clk) begin
      if (bus.readdatavalid) begin
         if (rdq.size() == 0) check_val("rdv_spurious", 128'(bus.readdatavalid), 128'd0);
         else begin
            rd_t e;
            e = rdq.pop_front();
            check_val("rd_data", 128'(bus.readdata), 128'(e.d));
            check_val("rd_lat", 128'(cyc - e.c), 128'd1);
         end
      end
   end

   // Scoreboard pop for the watchdog instance.
   always @(negedge clk) begin
      if (bus_to.readdatavalid) begin
         if (rdq_to.size() == 0) check_val("rdv_to_spurious", 128'(bus_to.readdatavalid), 128'd0);
         else begin
            rd_t e;
            e = rdq_to.pop_front();
            check_val("rd_to_data", 128'(bus_to.readdata), 128'(e.d));
            check_val("rd_to_lat", 128'(cyc - e.c), 128'd1);
         end
      end
   end

   task automatic wr(input int a, input logic [31:0] d);
      bus.chipselect = 1'b1; bus.write = 1'b1; bus.read = 1'b0;
      bus.address = AW'(a); bus.writedata = d;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write = 1'b0;
   endtask

   task automatic rd(input int a, input logic [31:0] exp);
      rd_t e;
      bus.chipselect = 1'b1; bus.read = 1'b1; bus.write = 1'b0;
      bus.address = AW'(a);
      e.d = exp; e.c = cyc;
      rdq.push_back(e);
      @(negedge clk);
      bus.chipselect = 1'b0; bus.read = 1'b0;
   endtask

   task automatic wr_to(input int a, input logic [31:0] d);
      bus_to.chipselect = 1'b1; bus_to.write = 1'b1; bus_to.read = 1'b0;
      bus_to.address = AW'(a); bus_to.writedata = d;
      @(negedge clk);
      bus_to.chipselect = 1'b0; bus_to.write = 1'b0;
   endtask

   task automatic rd_to(input int a, input logic [31:0] exp);
      rd_t e;
      bus_to.chipselect = 1'b1; bus_to.read = 1'b1; bus_to.write = 1'b0;
      bus_to.address = AW'(a);
      e.d = exp; e.c = cyc;
      rdq_to.push_back(e);
      @(negedge clk);
      bus_to.chipselect = 1'b0; bus_to.read = 1'b0;
   endtask

   task automatic pulse_done(input logic err);
      done = 1'b1; error = err;
      @(negedge clk);
      done = 1'b0; error = 1'b0;
   endtask

   initial begin
      bus.chipselect = 1'b0; bus.write = 1'b0; bus.read = 1'b0;
      bus.address = '0; bus.writedata = 32'h0;
      bus_to.chipselect = 1'b0; bus_to.write = 1'b0; bus_to.read = 1'b0;
      bus_to.address = '0; bus_to.writedata = 32'h0;
      done = 1'b0; error = 1'b0; done_to = 1'b0;
      ct_out = {2{64'hAAAAAAAAAAAAAAAA}};
      pt_out = 128'h0123456789ABCDEF_FEDCBA9876543210;
      tag_v  = 128'h11223344_55667788_99AABBCC_DDEEFF00;
      rst = 1'b1; rst_to = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0; rst_to = 1'b0;

      // Reset state.
      check_val("rst_irq", 128'(irq), 128'd0);
      check_val("rst_start", 128'(start), 128'd0);
      check_val("rst_rdv", 128'(bus.readdatavalid), 128'd0);
      check_val("rst_key", key, 128'd0);
      rd(1, 32'h0);

      // Load operands and check packing onto the core ports.
      wr(2, 32'h00010203); wr(3, 32'h04050607); wr(4, 32'h08090A0B); wr(5, 32'h0C0D0E0F);
      check_val("key_out", key, 128'h00010203_04050607_08090A0B_0C0D0E0F);
      for (int i = 0; i < 4; i++) wr(6 + i, 32'hA0000000 + 32'(i));
      check_val("nonce_out", nonce, 128'hA0000000_A0000001_A0000002_A0000003);
      for (int i = 0; i < 4; i++) wr(10 + i, 32'h11110000 + 32'(i));
      check_val("ad_out", 128'(ad), 128'h11110002_11110003_11110000_11110001);
      for (int i = 0; i < 4; i++) wr(14 + i, 32'h22220000 + 32'(i));
      check_val("pt_out", 128'(pt_in), 128'h22220002_22220003_22220000_22220001);
      rd(11, 32'h11110001);

      // Encrypt run with irq enabled.
      wr(0, 32'h9);
      t0 = cyc;
      check_val("start_hi", 128'(start), 128'd1);
      check_val("mode_enc", 128'(mode), 128'd0);
      @(negedge clk);
      check_val("start_lo", 128'(start), 128'd0);
      rd(1, 32'h1);
      wr(2, 32'hDEADBEEF);
      check_val("key_locked", key, 128'h00010203_04050607_08090A0B_0C0D0E0F);
      wr(0, 32'h9);
      rd(1, 32'h11);
      while (cyc < t0 + 20) @(negedge clk);
      pulse_done(1'b0);
      repeat (2) @(negedge clk);
      check_val("irq_done", 128'(irq), 128'd1);
      check_val("start_count", 128'(n_start), 128'd1);
      ct_out = '0;
      rd(18, 32'hAAAAAAAA);
      rd(21, 32'hAAAAAAAA);
      rd(22, 32'h11223344);
      rd(25, 32'hDDEEFF00);
      rd(1, 32'h12);
      wr(1, 32'h10);
      rd(1, 32'h2);
      check_val("irq_still", 128'(irq), 128'd1);
      wr(1, 32'h2);
      check_val("irq_clr", 128'(irq), 128'd0);
      rd(1, 32'h0);

      // Decrypt run with error; W1C of err in the capture cycle loses.
      wr(0, 32'h3);
      check_val("mode_dec", 128'(mode), 128'd1);
      repeat (5) @(negedge clk);
      pulse_done(1'b1);
      wr(1, 32'h4);
      rd(1, 32'h6);
      rd(18, 32'hFEDCBA98);
      rd(20, 32'h01234567);
      check_val("irq_masked", 128'(irq), 128'd0);

      // Stray done while idle must not capture or set status.
      wr(1, 32'h6);
      pt_out = '0;
      pulse_done(1'b1);
      rd(1, 32'h0);
      rd(18, 32'hFEDCBA98);

      // Reset in the middle of a run.
      ct_out = {2{64'hAAAAAAAAAAAAAAAA}};
      wr(0, 32'h9);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_val("mrst_irq", 128'(irq), 128'd0);
      check_val("mrst_start", 128'(start), 128'd0);
      check_val("mrst_key", key, 128'd0);
      check_val("mrst_ad", 128'(ad), 128'd0);
      check_val("mrst_mode", 128'(mode), 128'd0);
      check_val("mrst_rdata", 128'(bus.readdata), 128'd0);
      rst = 1'b0;
      pulse_done(1'b0);
      @(negedge clk);
      rd(1, 32'h0);
      rd(18, 32'h0);
      rd(0, 32'h0);

      // Watchdog: 16 BUSY cycles, then IDLE with to_st and no capture.
      wr_to(0, 32'h9);
      check_val("to_start", 128'(start_to), 128'd1);
      repeat (16) @(negedge clk);
      rd_to(1, 32'h1);
      rd_to(1, 32'h8);
      rd_to(18, 32'h0);
      rd_to(22, 32'h0);
      check_val("to_irq", 128'(irq_to), 128'd1);

      repeat (3) @(negedge clk);
      check_val("rdq_empty", 128'(rdq.size() + rdq_to.size()), 128'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
